// File: rtl/img_median_loader.sv
// img_median_loader: loads an IMG_DIM x IMG_DIM frame over a valid/ready stream, then streams its 3x3 median.
// Define BORDER_REPLICATE_EN to filter every pixel with clamped borders; otherwise only interior pixels are emitted.
module img_median_loader #(
    parameter int IMG_DIM     = 20,
    parameter int BIT_LENGTH  = 5,
    parameter int PIX_PER_CYC = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [PIX_PER_CYC*BIT_LENGTH-1:0] pixel_in,
    input  logic                              load_end,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [BIT_LENGTH-1:0]             pixel_out,
    output logic                              out_last,
    output logic                              busy,
    output logic                              err_overflow
);
    localparam int TOTAL = IMG_DIM * IMG_DIM;
    localparam int CW    = $clog2(IMG_DIM);
    localparam int IW    = $clog2(TOTAL);
    localparam int LW    = $clog2(TOTAL + PIX_PER_CYC);
`ifdef BORDER_REPLICATE_EN
    localparam logic [CW-1:0] LO = '0;
    localparam logic [CW-1:0] HI = CW'(IMG_DIM - 1);
`else
    localparam logic [CW-1:0] LO = CW'(1);
    localparam logic [CW-1:0] HI = CW'(IMG_DIM - 2);
`endif

    typedef enum logic [1:0] {LOAD, FILTER, DONE} state_t;

    state_t                state, state_next;
    logic [LW-1:0]         load_index;
    logic [CW-1:0]         row, col;
    logic [BIT_LENGTH-1:0] frame [TOTAL];
    logic [BIT_LENGTH-1:0] win [9];
    logic [BIT_LENGTH-1:0] median;
    logic                  accept, drop, advance, last;

    assign in_ready = (state == LOAD);
    assign busy     = (state != LOAD);
    assign accept   = in_valid && in_ready;
    assign drop     = int'(load_index) + PIX_PER_CYC > TOTAL;
    assign advance  = (state == FILTER) && (!out_valid || out_ready);
    assign last     = (row == HI) && (col == HI);

    // Coordinates are always clamped; without replication the counters stay interior so clamping never bites.
    always_comb begin
        int rr, cc, lt, le;
        rr = 0;
        cc = 0;
        lt = 0;
        le = 0;
        median = '0;
        for (int i = 0; i < 9; i++) begin
            rr = int'(row) + i / 3 - 1;
            cc = int'(col) + i % 3 - 1;
            rr = rr < 0 ? 0 : (rr > IMG_DIM - 1 ? IMG_DIM - 1 : rr);
            cc = cc < 0 ? 0 : (cc > IMG_DIM - 1 ? IMG_DIM - 1 : cc);
            win[i] = frame[IW'(rr * IMG_DIM + cc)];
        end
        // A window member is the median when at most 4 values are below it and at least 5 are at or below it.
        for (int i = 0; i < 9; i++) begin
            lt = 0;
            le = 0;
            for (int j = 0; j < 9; j++) begin
                lt += (win[j] < win[i]) ? 1 : 0;
                le += (win[j] <= win[i]) ? 1 : 0;
            end
            if (lt <= 4 && le >= 5) median = win[i];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    state_next = (accept && load_end) ? FILTER : LOAD;
            FILTER:  state_next = (advance && last) ? DONE : FILTER;
            default: state_next = out_ready ? LOAD : DONE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= LOAD;
            load_index   <= '0;
            row          <= '0;
            col          <= '0;
            out_valid    <= 1'b0;
            pixel_out    <= '0;
            out_last     <= 1'b0;
            err_overflow <= 1'b0;
            for (int i = 0; i < TOTAL; i++) frame[i] <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                for (int k = 0; k < PIX_PER_CYC; k++)
                    if (int'(load_index) + k < TOTAL)
                        frame[IW'(int'(load_index) + k)] <= pixel_in[k*BIT_LENGTH +: BIT_LENGTH];
                err_overflow <= (load_index != '0 && err_overflow) || drop;
                // Past the end every lane drops, so the index saturates instead of wrapping.
                load_index   <= load_end ? '0 :
                                (int'(load_index) < TOTAL ? load_index + LW'(PIX_PER_CYC) : load_index);
                if (load_end) begin
                    row <= LO;
                    col <= LO;
                end
            end
            if (advance) begin
                pixel_out <= median;
                out_valid <= 1'b1;
                out_last  <= last;
                if (!last) begin
                    col <= (col == HI) ? LO : col + CW'(1);
                    row <= (col == HI) ? row + CW'(1) : row;
                end
            end
            if (state == DONE && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end
endmodule

// File: doc/img_median_loader.md
Name: img_median_loader

Overview:
- Parametrised successor of the fixed 20x20 / 3-pixel image loader front end.
- Loads a square frame of IMG_DIM x IMG_DIM pixels into an internal register file over a valid/ready input stream, PIX_PER_CYC pixels per beat.
- Then applies a 3x3 median filter and streams the result out in raster order over a valid/ready output handshake.
- Sits ahead of the Gaussian/Sobel stages as the noise-removal step of the edge/colour pipeline.

Parameters:
- IMG_DIM, 20, frame width and height in pixels (>=4).
- BIT_LENGTH, 5, bits per pixel.
- PIX_PER_CYC, 3, pixels per input beat (1..8).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block accepts input beats (high only in LOAD)
- pixel_in  input  PIX_PER_CYC*BIT_LENGTH  lane k at bits [k*BIT_LENGTH +: BIT_LENGTH]; lane 0 = lowest raster index
- load_end  input  1  qualifies the final beat of a frame
- out_valid  output  1  pixel_out valid
- out_ready  input  1  downstream accepts pixel_out
- pixel_out  output  BIT_LENGTH  filtered pixel
- out_last  output  1  marks the final output pixel of the frame
- busy  output  1  high in FILTER or DONE
- err_overflow  output  1  sticky: a lane addressed index >= IMG_DIM*IMG_DIM

Behaviour:
- Reset (already decided): reset, asynchronous, active-high; clock clk.
- Reset values:
  - state=LOAD, load_index=0, row=col=0.
  - all frame registers = 0.
  - out_valid=0, pixel_out=0, out_last=0, busy=0, err_overflow=0, in_ready=1.
- Reset mid-frame or mid-filter aborts immediately; no partial output is completed.
- State LOAD:
  - A beat is accepted when in_valid && in_ready.
  - On accept, lane k is written to index load_index+k. Then load_index += PIX_PER_CYC.
  - Lanes with index >= TOTAL=IMG_DIM*IMG_DIM are dropped and set err_overflow.
  - Accepted beat with load_end=1 -> FILTER next cycle, load_index cleared.
  - Pixels not written this frame keep their previous values.
- err_overflow clears on the first accepted beat of the next frame, then may re-set on that same beat.
- State FILTER:
  - Raster counters row, col.
  - When the output register is empty or is consumed this cycle (out_valid && out_ready), the median for (row,col) is registered into pixel_out with out_valid=1, and the counters advance.
  - First out_valid is asserted on the 2nd cycle after the load_end beat.
  - Steady throughput is 1 pixel/cycle with out_ready held high.
  - After the final pixel is registered -> DONE.
- State DONE: waits for the final handshake, then -> LOAD (in_ready=1 the next cycle).
- Output handshake rules:
  - pixel_out and out_last are stable while out_valid && !out_ready.
  - No pixel is dropped or duplicated.
- Median: the 5th-smallest of the 9 window values, unsigned. Ties are counted; the result is an exact window member. Pure combinational select feeding the output register; no arithmetic overflow possible.
- Window neighbours come from the frame register file. Border handling is set by the optional feature below.
- busy = (state != LOAD).

Optional Feature:
- Macro: BORDER_REPLICATE_EN.
- Defined:
  - Outputs all TOTAL pixels; row and col run 0..IMG_DIM-1.
  - Out-of-frame neighbour coordinates are clamped to 0..IMG_DIM-1 (edge replication).
  - out_last on output number TOTAL.
- Undefined:
  - Outputs interior pixels only; row and col run 1..IMG_DIM-2.
  - (IMG_DIM-2)^2 outputs.
  - out_last on output number (IMG_DIM-2)^2.

Test Plan:
- Defaults, constant frame of value 7, 134 beats, load_end on beat 134 -> all outputs 7; out_last on output 400 (macro) or 324 (no macro); in_ready returns to 1 after the last handshake.
- Zero frame with a single 31 at (5,5) -> every output 0 (impulse removed).
- IMG_DIM=4, PIX_PER_CYC=1, pixel = r*4+c:
  - output at (1,1) = 5, at (2,2) = 10.
  - with macro, (0,0) = 1 and (3,3) = 14.
- Backpressure: out_ready low for 10 cycles mid-frame -> out_valid held 1, pixel_out unchanged; full output count still correct and in order.
- Defaults, 135 beats with load_end on beat 135 -> err_overflow=1, indices 0..399 hold the first 400 lanes; a following clean frame clears the flag on its first beat.
- Assert reset during FILTER -> out_valid=0, busy=0, in_ready=1, err_overflow=0; next frame filters correctly from zeroed registers.
